sd_block_arbiter: RTL and testbench

//  Shares the single hps_io SD block channel (sd_lba/sd_rd/sd_wr/sd_ack) and port A of the
//  512-byte sector buffer between NREQ block requesters, e.g. the ZPU disk bridge and a cart NVRAM saver.

---
 rtl/sd_arb_pkg.sv | 15 +
 rtl/sd_rr_picker.sv | 30 +++
 rtl/sd_block_arbiter.sv | 204 ++++++++++++++++++++
 tb/tb_sd_block_arbiter.sv | 305 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sd_arb_pkg.sv
// Shared types and constants for the SD block-channel arbiter.
// Imported by sd_rr_picker and sd_block_arbiter.
package sd_arb_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        XFER,
        FIN
    } state_t;

    localparam int SECTOR_BYTES  = 512;
    localparam int LBA_W_DEFAULT = 32;

endpackage

// File: rtl/sd_rr_picker.sv
// Combinational round-robin priority encoder: the search starts one past the last
// winner, so the most recently served requester has the lowest priority.
module sd_rr_picker
    import sd_arb_pkg::*;
#(
    parameter int NREQ  = 2,
    parameter int IDX_W = $clog2(NREQ)
) (
    input  logic [NREQ-1:0]  pend,
    input  logic [IDX_W-1:0] last,
    output logic             valid,
    output logic [IDX_W-1:0] idx
);

    int j;

    // Walk the search order backwards so the closest pending requester is written last.
    always_comb begin
        valid = |pend;
        idx   = '0;
        j     = 0;
        for (int k = NREQ; k >= 1; k--) begin
            j = (int'(last) + k) % NREQ;
            if (pend[j]) begin
                idx = IDX_W'(j);
            end
        end
    end

endmodule

// File: rtl/sd_block_arbiter.sv
// Shares the hps_io SD block channel and sector-buffer port A among NREQ requesters.
// Optional watchdog on a stalled transfer is enabled by defining SD_TIMEOUT_EN.
module sd_block_arbiter
    import sd_arb_pkg::*;
#(
    parameter int NREQ      = 2,
    parameter int LBA_W     = LBA_W_DEFAULT,
    parameter int TIMEOUT_W = 24,
    localparam int IDX_W    = $clog2(NREQ)
) (
    input  logic                  clk_sys,
    input  logic                  reset,
    input  logic [NREQ-1:0]       req_rd,
    input  logic [NREQ-1:0]       req_wr,
    input  logic [NREQ*LBA_W-1:0] req_lba,
    output logic [NREQ-1:0]       done,
    output logic [NREQ-1:0]       err,
    output logic [IDX_W-1:0]      grant_id,
    output logic                  busy,
    output logic [LBA_W-1:0]      sd_lba,
    output logic                  sd_rd,
    output logic                  sd_wr,
    input  logic                  sd_ack,
    input  logic                  img_mounted
);

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   grant_q, grant_d;
    logic [IDX_W-1:0]   last_q, last_d;
    logic [LBA_W-1:0]   lba_q, lba_d;
    logic               rd_q, rd_d;
    logic               wr_q, wr_d;
    logic               busy_q, busy_d;
    logic               flag_q, flag_d;
    logic [NREQ-1:0]    done_q, done_d;
    logic [NREQ-1:0]    err_q, err_d;
    logic               ack_q;
    logic               mnt_q;

    logic [NREQ-1:0]    pend;
    logic [LBA_W-1:0]   lba_arr [NREQ];
    logic               pick_valid;
    logic [IDX_W-1:0]   pick_idx;
    logic               finish;
    logic               fin_err;
    logic               tmo;
    logic               mnt_rise;

    genvar gi;
    generate
        for (gi = 0; gi < NREQ; gi++) begin : g_req
            assign pend[gi]    = req_rd[gi] | req_wr[gi];
            assign lba_arr[gi] = req_lba[gi*LBA_W +: LBA_W];
        end
    endgenerate

    sd_rr_picker #(
        .NREQ  (NREQ),
        .IDX_W (IDX_W)
    ) u_picker (
        .pend  (pend),
        .last  (last_q),
        .valid (pick_valid),
        .idx   (pick_idx)
    );

    assign mnt_rise = img_mounted & ~mnt_q;

`ifdef SD_TIMEOUT_EN
    logic [TIMEOUT_W-1:0] timer_q, timer_d;

    always_comb begin
        timer_d = timer_q;
        if ((state_q == IDLE && state_d == ISSUE) || (state_q == ISSUE && state_d == XFER)) begin
            timer_d = '0;
        end else if (state_q == ISSUE || state_q == XFER) begin
            timer_d = timer_q + 1'b1;
        end
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            timer_q <= '0;
        end else begin
            timer_q <= timer_d;
        end
    end

    assign tmo = &timer_q;
`else
    assign tmo = 1'b0;
`endif

    // done/err are raised on the transition into FIN, so the pulse is visible during FIN
    // and a requester dropping its req on done is already low when IDLE samples again.
    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        last_d  = last_q;
        lba_d   = lba_q;
        rd_d    = rd_q;
        wr_d    = wr_q;
        busy_d  = busy_q;
        flag_d  = flag_q;
        done_d  = '0;
        err_d   = '0;
        finish  = 1'b0;
        fin_err = 1'b0;
        case (state_q)
            IDLE: begin
                if (pick_valid) begin
                    grant_d = pick_idx;
                    lba_d   = lba_arr[pick_idx];
                    busy_d  = 1'b1;
                    if (req_rd[pick_idx] & req_wr[pick_idx]) begin
                        flag_d  = 1'b1;
                        finish  = 1'b1;
                        fin_err = 1'b1;
                    end else begin
                        flag_d  = 1'b0;
                        rd_d    = req_rd[pick_idx];
                        wr_d    = req_wr[pick_idx];
                        state_d = ISSUE;
                    end
                end
            end
            ISSUE: begin
                if (mnt_rise || tmo) begin
                    rd_d    = 1'b0;
                    wr_d    = 1'b0;
                    flag_d  = 1'b1;
                    finish  = 1'b1;
                    fin_err = 1'b1;
                end else if (sd_ack) begin
                    rd_d    = 1'b0;
                    wr_d    = 1'b0;
                    state_d = XFER;
                end
            end
            XFER: begin
                if (ack_q && !sd_ack) begin
                    finish  = 1'b1;
                    fin_err = flag_q;
                end else if (tmo) begin
                    flag_d  = 1'b1;
                    finish  = 1'b1;
                    fin_err = 1'b1;
                end
            end
            FIN: begin
                busy_d  = 1'b0;
                last_d  = grant_q;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        if (finish) begin
            state_d         = FIN;
            done_d[grant_d] = 1'b1;
            err_d[grant_d]  = fin_err;
        end
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            state_q <= IDLE;
            grant_q <= '0;
            last_q  <= '0;
            lba_q   <= '0;
            rd_q    <= 1'b0;
            wr_q    <= 1'b0;
            busy_q  <= 1'b0;
            flag_q  <= 1'b0;
            done_q  <= '0;
            err_q   <= '0;
            ack_q   <= 1'b0;
            mnt_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            last_q  <= last_d;
            lba_q   <= lba_d;
            rd_q    <= rd_d;
            wr_q    <= wr_d;
            busy_q  <= busy_d;
            flag_q  <= flag_d;
            done_q  <= done_d;
            err_q   <= err_d;
            ack_q   <= sd_ack;
            mnt_q   <= img_mounted;
        end
    end

    assign done     = done_q;
    assign err      = err_q;
    assign grant_id = grant_q;
    assign busy     = busy_q;
    assign sd_lba   = lba_q;
    assign sd_rd    = rd_q;
    assign sd_wr    = wr_q;

endmodule

// File: tb/tb_sd_block_arbiter.sv
// Scoreboard bench for sd_block_arbiter: expected SD commands and done/err pulses
// are queued by the stimulus and checked by independent monitors.
module tb_sd_block_arbiter;

    localparam int NREQ  = 2;
    localparam int LBA_W = 32;

    typedef struct {
        int id;
        bit e;
    } done_t;

    typedef struct {
        logic [31:0] lba;
        bit          rd;
        bit          wr;
    } cmd_t;

    logic                  clk_sys = 1'b0;
    logic                  reset = 1'b1;
    logic [NREQ-1:0]       req_rd = '0;
    logic [NREQ-1:0]       req_wr = '0;
    logic [NREQ*LBA_W-1:0] req_lba = '0;
    logic [NREQ-1:0]       done;
    logic [NREQ-1:0]       err;
    logic [0:0]            grant_id;
    logic                  busy;
    logic [LBA_W-1:0]      sd_lba;
    logic                  sd_rd;
    logic                  sd_wr;
    logic                  sd_ack = 1'b0;
    logic                  img_mounted = 1'b0;

    int    checks = 0;
    int    errors = 0;
    bit    hps_en = 1'b0;
    bit    prev_cmd = 1'b0;
    done_t done_exp[$];
    cmd_t  cmd_exp[$];

    sd_block_arbiter #(
        .NREQ      (NREQ),
        .LBA_W     (LBA_W),
        .TIMEOUT_W (4)
    ) dut (
        .clk_sys     (clk_sys),
        .reset       (reset),
        .req_rd      (req_rd),
        .req_wr      (req_wr),
        .req_lba     (req_lba),
        .done        (done),
        .err         (err),
        .grant_id    (grant_id),
        .busy        (busy),
        .sd_lba      (sd_lba),
        .sd_rd       (sd_rd),
        .sd_wr       (sd_wr),
        .sd_ack      (sd_ack),
        .img_mounted (img_mounted)
    );

    always #5 clk_sys = ~clk_sys;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end else begin
            $display("ok   %s = %0h", name, act);
        end
    endtask

    task automatic push_cmd(input logic [31:0] lba, input bit rd, input bit wr);
        cmd_t c;
        c.lba = lba;
        c.rd  = rd;
        c.wr  = wr;
        cmd_exp.push_back(c);
    endtask

    task automatic push_done(input int id, input bit e);
        done_t d;
        d.id = id;
        d.e  = e;
        done_exp.push_back(d);
    endtask

    task automatic wait_idle(input string name, input int budget);
        bit ok;
        ok = 1'b0;
        for (int n = 0; n < budget; n++) begin
            @(posedge clk_sys);
            #1;
            if (!busy && done_exp.size() == 0) begin
                ok = 1'b1;
                break;
            end
        end
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s_timeout actual=busy%0d/pending%0d required=idle/0", name, busy, done_exp.size());
        end
    endtask

    // Requesters hold their level until they see their done pulse.
    initial begin
        forever begin
            @(negedge clk_sys);
            for (int i = 0; i < NREQ; i++) begin
                if (done[i]) begin
                    req_rd[i] = 1'b0;
                    req_wr[i] = 1'b0;
                end
            end
        end
    end

    // hps_io stand-in: ack two cycles after a command, held for three cycles.
    initial begin
        forever begin
            @(posedge clk_sys);
            if (hps_en && (sd_rd || sd_wr) && !sd_ack) begin
                repeat (2) @(posedge clk_sys);
                #1 sd_ack = 1'b1;
                repeat (3) @(posedge clk_sys);
                #1 sd_ack = 1'b0;
            end
        end
    end

    // Done monitor.
    initial begin
        done_t d;
        forever begin
            @(negedge clk_sys);
            if (done != '0 || err != '0) begin
                checks++;
                if (done_exp.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_done actual=done%b/err%b required=none", done, err);
                end else begin
                    d = done_exp.pop_front();
                    if (done !== NREQ'(1 << d.id) || err !== (d.e ? NREQ'(1 << d.id) : NREQ'(0))) begin
                        errors++;
                        $display("FAIL done_pulse actual=done%b/err%b required=id%0d/err%0d", done, err, d.id, d.e);
                    end else begin
                        $display("ok   done_pulse id=%0d err=%0d", d.id, d.e);
                    end
                end
            end
        end
    end

    // Command monitor: checks each new SD command against the expected queue.
    initial begin
        cmd_t c;
        bit   cur;
        forever begin
            @(negedge clk_sys);
            cur = sd_rd | sd_wr;
            if (cur && !prev_cmd) begin
                checks++;
                if (cmd_exp.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_cmd actual=lba%0h/rd%0d/wr%0d required=none", sd_lba, sd_rd, sd_wr);
                end else begin
                    c = cmd_exp.pop_front();
                    if (sd_lba !== c.lba || sd_rd !== c.rd || sd_wr !== c.wr) begin
                        errors++;
                        $display("FAIL sd_cmd actual=lba%0h/rd%0d/wr%0d required=lba%0h/rd%0d/wr%0d",
                                 sd_lba, sd_rd, sd_wr, c.lba, c.rd, c.wr);
                    end else begin
                        $display("ok   sd_cmd lba=%0h rd=%0d wr=%0d", c.lba, c.rd, c.wr);
                    end
                end
            end
            prev_cmd = cur;
        end
    end

    initial begin
        #200000;
        $display("FAIL global_watchdog actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(posedge clk_sys);
        #1 reset = 1'b0;
        @(posedge clk_sys);
        #1;
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        chk("rst_cmd", {sd_rd, sd_wr}, 0);
        chk("rst_lba", sd_lba, 0);
        chk("rst_busy_grant", {busy, grant_id}, 0);

        // Single read from requester 0.
        hps_en = 1'b1;
        req_lba[0*LBA_W +: LBA_W] = 32'h10;
        req_rd[0] = 1'b1;
        push_cmd(32'h10, 1'b1, 1'b0);
        push_done(0, 1'b0);
        @(posedge clk_sys);
        #1;
        chk("t1_sd_rd", sd_rd, 1);
        chk("t1_lba_busy", {sd_lba, busy}, {32'h10, 1'b1});
        wait_idle("t1", 30);

        // Simultaneous writes: last_grant=0 so requester 1 goes first.
        req_lba = {32'h21, 32'h20};
        req_wr  = 2'b11;
        push_cmd(32'h21, 1'b0, 1'b1);
        push_cmd(32'h20, 1'b0, 1'b1);
        push_done(1, 1'b0);
        push_done(0, 1'b0);
        @(posedge clk_sys);
        #1;
        chk("t2_first_grant", grant_id, 1);
        wait_idle("t2", 60);

        // Requester 1 asks for read and write together: aborted without a command.
        req_lba[1*LBA_W +: LBA_W] = 32'h30;
        req_rd[1] = 1'b1;
        req_wr[1] = 1'b1;
        push_done(1, 1'b1);
        @(posedge clk_sys);
        #1;
        chk("t3_no_cmd", {sd_rd, sd_wr}, 0);
        chk("t3_done_err", {done, err}, 4'b1010);
        wait_idle("t3", 10);

        // Medium change while the command is outstanding.
        hps_en = 1'b0;
        req_lba[0*LBA_W +: LBA_W] = 32'h40;
        req_rd[0] = 1'b1;
        push_cmd(32'h40, 1'b1, 1'b0);
        push_done(0, 1'b1);
        @(posedge clk_sys);
        #1 img_mounted = 1'b1;
        @(posedge clk_sys);
        #1;
        chk("t4_rd_dropped", sd_rd, 0);
        chk("t4_done_err", {done, err}, 4'b0101);
        img_mounted = 1'b0;
        repeat (2) @(posedge clk_sys);
        #1 sd_ack = 1'b1;
        repeat (3) @(posedge clk_sys);
        #1 sd_ack = 1'b0;
        repeat (4) @(posedge clk_sys);
        #1;
        chk("t4_idle_after_ack", busy, 0);

        // No ack at all.
        req_lba[0*LBA_W +: LBA_W] = 32'h50;
        req_rd[0] = 1'b1;
        push_cmd(32'h50, 1'b1, 1'b0);
`ifdef SD_TIMEOUT_EN
        push_done(0, 1'b1);
        wait_idle("t5_watchdog", 30);
        chk("t5_rd_cleared", sd_rd, 0);
`else
        repeat (40) @(posedge clk_sys);
        #1;
        chk("t5_still_busy", {busy, sd_rd}, 2'b11);
        reset = 1'b1;
        req_rd[0] = 1'b0;
        @(posedge clk_sys);
        #1 reset = 1'b0;
        chk("t5_reset_idle", busy, 0);
`endif

        // Reset while in XFER; the late ack fall must not produce done.
        req_lba[0*LBA_W +: LBA_W] = 32'h60;
        req_rd[0] = 1'b1;
        push_cmd(32'h60, 1'b1, 1'b0);
        @(posedge clk_sys);
        #1;
        chk("t6_sd_rd", sd_rd, 1);
        sd_ack = 1'b1;
        @(posedge clk_sys);
        #1;
        chk("t6_in_xfer", {busy, sd_rd}, 2'b10);
        reset = 1'b1;
        req_rd[0] = 1'b0;
        @(posedge clk_sys);
        #1;
        chk("t6_rst_outputs", {done, err, sd_rd, sd_wr, busy, grant_id}, 0);
        chk("t6_rst_lba", sd_lba, 0);
        reset = 1'b0;
        @(posedge clk_sys);
        #1 sd_ack = 1'b0;
        repeat (5) @(posedge clk_sys);
        #1;
        chk("t6_no_done_busy", {busy, done}, 0);

        chk("leftover_done", done_exp.size(), 0);
        chk("leftover_cmd", cmd_exp.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
